// File: rtl/store_write_buffer_if.sv
// Bus bundle for the store write buffer: MEM-stage store/load port, memory drain port and fence.
// The master side is the pipeline/memory environment, the slave side is the buffer.
interface store_write_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    logic              fence;

    modport master (
        output st_valid, st_addr, st_data, ld_req, ld_addr, mem_ready, fence,
        input  st_ready, ld_hit, ld_data, mem_valid, mem_addr, mem_data
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_req, ld_addr, mem_ready, fence,
        output st_ready, ld_hit, ld_data, mem_valid, mem_addr, mem_data
    );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-write buffer between MEM stage and data memory: in-order circular FIFO of word stores
// with store-to-load forwarding and coalescing of repeated stores to a non-head entry.
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    store_write_buffer_if.slave     bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    idle
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;

    logic [DEPTH-1:0]  ent_valid;
    logic [WA_W-1:0]   ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q;

    logic [WA_W-1:0]   st_waddr;
    logic [WA_W-1:0]   ld_waddr;
    logic              empty;
    logic              full;
    logic              coalesce_hit;
    logic [PTR_W-1:0]  coalesce_idx;
    logic              head_hit;
    logic              young_hit;
    logic [PTR_W-1:0]  young_idx;
    logic              st_ready;
    logic              accept;
    logic              alloc;
    logic              drain;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              unused_addr_bits;

    assign st_waddr = bus.st_addr[ADDR_W-1:2];
    assign ld_waddr = bus.ld_addr[ADDR_W-1:2];
    assign unused_addr_bits = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // The head may already be in flight, so only younger entries are coalescing targets.
    always_comb begin
        coalesce_hit = 1'b0;
        coalesce_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == st_waddr) && (PTR_W'(i) != rd_ptr)) begin
                coalesce_hit = 1'b1;
                coalesce_idx = PTR_W'(i);
            end
        end
    end

    // At most one non-head entry can share an address, and it is always younger than the head.
    always_comb begin
        young_hit = 1'b0;
        young_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == ld_waddr) && (PTR_W'(i) != rd_ptr)) begin
                young_hit = 1'b1;
                young_idx = PTR_W'(i);
            end
        end
    end

    assign head_hit = ent_valid[rd_ptr] && (ent_addr[rd_ptr] == ld_waddr);

    always_comb begin
        ld_hit  = bus.ld_req && (head_hit || young_hit);
        ld_data = '0;
        if (ld_hit) begin
            ld_data = young_hit ? ent_data[young_idx] : ent_data[rd_ptr];
        end
    end

    assign st_ready = !bus.fence && (!full || coalesce_hit);
    assign accept   = bus.st_valid && st_ready;
    assign alloc    = accept && !coalesce_hit;
    assign drain    = !empty && bus.mem_ready;

    assign bus.st_ready  = st_ready;
    assign bus.ld_hit    = ld_hit;
    assign bus.ld_data   = ld_data;
    assign bus.mem_valid = !empty;
    assign bus.mem_addr  = empty ? '0 : {ent_addr[rd_ptr], 2'b00};
    assign bus.mem_data  = empty ? '0 : ent_data[rd_ptr];
    assign count = count_q;
    assign idle  = empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            ent_valid <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_q   <= '0;
        end else begin
            if (drain) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PTR_W'(1);
            end
            if (alloc) begin
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            case ({alloc, drain})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset: every read of it is qualified by a valid bit or the empty flag.
    always_ff @(posedge clock) begin
        if (alloc) begin
            ent_addr[wr_ptr] <= st_waddr;
            ent_data[wr_ptr] <= bus.st_data;
        end else if (accept) begin
            ent_data[coalesce_idx] <= bus.st_data;
        end
    end
endmodule
